// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and data (load/store) access.
// Define UMA_TIMEOUT_EN to enable the watchdog that aborts stalled transactions after TIMEOUT_CYCLES.
module unified_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_busy,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_busy,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);
  localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} stateT;

  stateT state, nextState;
  logic  grantData, grantFetch, txnEnd, timeoutHit;

  // A stage's own done blocks its re-grant, so a request held through done is served once.
  assign if_busy = if_req & ~if_done;
  assign d_busy  = d_req & ~d_done;
  assign txnEnd  = (state != IDLE) && (mem_ready || timeoutHit);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    nextState  = state;
    grantData  = 1'b0;
    grantFetch = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && !d_done) begin
          grantData = 1'b1;
          nextState = DATA;
        end else if (if_req && !if_done) begin
          grantFetch = 1'b1;
          nextState  = FETCH;
        end
      end
      FETCH, DATA: if (txnEnd) nextState = IDLE;
      default:     nextState = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state   <= nextState;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if (grantData) begin
        mem_valid <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wstrb <= d_we ? d_wstrb : '0;
      end else if (grantFetch) begin
        mem_valid <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end else if (txnEnd) begin
        mem_valid <= 1'b0;
        if (state == FETCH) begin
          if_done  <= 1'b1;
          if_rdata <= timeoutHit ? NOP_INSN : mem_rdata;
        end else begin
          d_done <= 1'b1;
          // Stores leave the last load result untouched.
          if (!mem_we) d_rdata <= timeoutHit ? '0 : mem_rdata;
        end
      end
    end
  end

`ifdef UMA_TIMEOUT_EN
  logic [15:0] waitCnt;
  logic        busErr;

  // Fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
  assign timeoutHit = (state != IDLE) && !mem_ready && (waitCnt == 16'(TIMEOUT_CYCLES - 1));
  assign bus_err    = busErr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      waitCnt <= '0;
      busErr  <= 1'b0;
    end else begin
      if (grantData || grantFetch)         waitCnt <= '0;
      else if (state != IDLE && !mem_ready) waitCnt <= waitCnt + 16'd1;
      if (timeoutHit) busErr <= 1'b1;
    end
  end
`else
  logic unusedTimeoutCfg;

  assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
  assign timeoutHit       = 1'b0;
  assign bus_err          = 1'b0;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level memory model. All stimulus is driven and sampled at the falling edge.
module tb_unified_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_busy;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_busy;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_err;

  int          nCompared = 0;
  int          nMismatched = 0;
  logic [31:0] expDRdata = '0;
  logic [31:0] refMem  [logic [31:0]];
  logic [31:0] bankMem [logic [31:0]];

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_busy(if_busy),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata), .d_busy(d_busy),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1);
  end

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return initWord(a);
  endfunction

  function automatic void refStore(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w = refRead(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    refMem[a] = w;
  endfunction

  function automatic logic [31:0] bankRead(input logic [31:0] a);
    if (bankMem.exists(a)) return bankMem[a];
    return initWord(a);
  endfunction

  function automatic void bankStore(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w = bankRead(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    bankMem[a] = w;
  endfunction

  function automatic logic [31:0] randAddr();
    return 32'h0000_2000 + (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic test_reset();
    RST = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge CLK);
    nCompared++;
    if ({mem_valid, mem_we, if_done, d_done, bus_err, if_busy, d_busy} !== 7'b0) begin
      nMismatched++;
      $display("FAIL reset_ctrl: got %b want 0000000", {mem_valid, mem_we, if_done, d_done, bus_err, if_busy, d_busy});
    end
    nCompared++;
    if ({mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata} !== 132'b0) begin
      nMismatched++;
      $display("FAIL reset_data: got %h %h %h %h %h want all 0", mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata);
    end
    RST = 1'b0;
    expDRdata = '0;
    @(negedge CLK);
    nCompared++;
    if (mem_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_idle: mem_valid got %b want 0", mem_valid); end
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge CLK);
    nCompared++;
    if ({mem_valid, mem_we, mem_wstrb, if_busy, if_done} !== 8'b1000_0010) begin
      nMismatched++;
      $display("FAIL fetch_grant: valid/we/strb/busy/done got %b want 10000010", {mem_valid, mem_we, mem_wstrb, if_busy, if_done});
    end
    nCompared++;
    if (mem_addr !== 32'h100) begin nMismatched++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge CLK);
    nCompared++;
    if ({if_done, mem_valid, if_busy} !== 3'b100) begin
      nMismatched++;
      $display("FAIL fetch_done: done/valid/busy got %b want 100", {if_done, mem_valid, if_busy});
    end
    nCompared++;
    if (if_rdata !== 32'h0050_0093) begin nMismatched++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
    mem_ready = 1'b0; mem_rdata = '0; if_req = 1'b0;
    @(negedge CLK);
    nCompared++;
    if ({if_done, mem_valid} !== 2'b00) begin nMismatched++; $display("FAIL fetch_pulse: done/valid got %b want 00", {if_done, mem_valid}); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] wd = $urandom;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wstrb = 4'hF; d_wdata = wd;
    @(negedge CLK);
    nCompared++;
    if ({mem_valid, mem_we, mem_wstrb, if_busy, d_busy} !== 8'b1111_1111) begin
      nMismatched++;
      $display("FAIL simul_data_first: valid/we/strb/ibusy/dbusy got %b want 11111111", {mem_valid, mem_we, mem_wstrb, if_busy, d_busy});
    end
    nCompared++;
    if ({mem_addr, mem_wdata} !== {32'h2000, wd}) begin
      nMismatched++;
      $display("FAIL simul_store_bus: addr/wdata got %h/%h want 00002000/%h", mem_addr, mem_wdata, wd);
    end
    mem_ready = 1'b1;
    @(negedge CLK);
    nCompared++;
    if ({d_done, if_done, mem_valid, if_busy} !== 4'b1001) begin
      nMismatched++;
      $display("FAIL simul_store_done: ddone/idone/valid/ibusy got %b want 1001", {d_done, if_done, mem_valid, if_busy});
    end
    nCompared++;
    if (d_rdata !== expDRdata) begin nMismatched++; $display("FAIL simul_store_rdata: got %h want %h", d_rdata, expDRdata); end
    mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge CLK);
    nCompared++;
    if ({mem_valid, mem_we, mem_wstrb, if_busy} !== 7'b1000_001 || mem_addr !== 32'h104) begin
      nMismatched++;
      $display("FAIL simul_fetch_next: valid/we/strb/busy got %b addr %h want 1000001 addr 00000104", {mem_valid, mem_we, mem_wstrb, if_busy}, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    nCompared++;
    if ({if_done, if_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      nMismatched++;
      $display("FAIL simul_fetch_done: done/rdata got %b/%h want 1/deadbeef", if_done, if_rdata);
    end
    mem_ready = 1'b0; if_req = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_slow_memory();
    logic [31:0] rd = $urandom;
    int doneCount = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wstrb = 4'($urandom); d_wdata = $urandom;
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      nCompared++;
      if ({mem_valid, mem_we, mem_addr} !== {2'b10, 32'h3000}) begin
        nMismatched++;
        $display("FAIL slow_stable_%0d: valid/we/addr got %b%b/%h want 10/00003000", i, mem_valid, mem_we, mem_addr);
      end
      if (d_done) doneCount++;
      d_addr = $urandom;  // must be ignored mid-transaction
      @(negedge CLK);
    end
    nCompared++;
    if ({mem_valid, mem_addr} !== {1'b1, 32'h3000}) begin
      nMismatched++;
      $display("FAIL slow_before_ready: valid/addr got %b/%h want 1/00003000", mem_valid, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = rd;
    @(negedge CLK);
    if (d_done) doneCount++;
    nCompared++;
    if ({d_done, mem_valid, d_rdata} !== {2'b10, rd}) begin
      nMismatched++;
      $display("FAIL slow_done: done/valid/rdata got %b%b/%h want 10/%h", d_done, mem_valid, d_rdata, rd);
    end
    expDRdata = rd;
    d_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; mem_rdata = $urandom;  // stray ready with nothing outstanding
      @(negedge CLK);
      if (d_done) doneCount++;
      nCompared++;
      if ({mem_valid, if_done, d_rdata} !== {2'b00, expDRdata}) begin
        nMismatched++;
        $display("FAIL stray_ready_%0d: valid/idone/drdata got %b%b/%h want 00/%h", i, mem_valid, if_done, d_rdata, expDRdata);
      end
    end
    mem_ready = 1'b0;
    nCompared++;
    if (doneCount !== 1) begin nMismatched++; $display("FAIL slow_done_count: got %0d want 1", doneCount); end
  endtask

  task automatic test_held_request();
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge CLK);
    mem_ready = 1'b1; mem_rdata = a;
    @(negedge CLK);
    nCompared++;
    if ({if_done, if_rdata} !== {1'b1, a}) begin nMismatched++; $display("FAIL held_first: done/rdata got %b/%h want 1/%h", if_done, if_rdata, a); end
    mem_ready = 1'b0; if_addr = 32'h204;
    @(negedge CLK);
    nCompared++;
    if ({mem_valid, if_done} !== 2'b00) begin nMismatched++; $display("FAIL held_no_regrant: valid/done got %b want 00", {mem_valid, if_done}); end
    @(negedge CLK);
    nCompared++;
    if ({mem_valid, mem_addr} !== {1'b1, 32'h204}) begin
      nMismatched++;
      $display("FAIL held_regrant: valid/addr got %b/%h want 1/00000204", mem_valid, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = b;
    @(negedge CLK);
    nCompared++;
    if ({if_done, if_rdata} !== {1'b1, b}) begin nMismatched++; $display("FAIL held_second: done/rdata got %b/%h want 1/%h", if_done, if_rdata, b); end
    mem_ready = 1'b0; if_req = 1'b0;
    @(negedge CLK);
  endtask

  // Random traffic from both stages against a latency-randomized memory; the scoreboard predicts
  // grants from the priority rule and read data from a word-level image of memory.
  task automatic test_random(input int nCycles);
    logic        pValid = 1'b0, pReady = 1'b0, pIfDone = 1'b0, pDDone = 1'b0;
    logic        dElig, fElig, sWe;
    logic [31:0] sAddr, sWdata, expRd;
    logic [3:0]  sStrb;
    int          owner = 0;  // 0 none, 1 fetch, 2 data
    int          respWait = 0;
    int          respLat = 1;
    for (int cyc = 0; cyc < nCycles + 80; cyc++) begin
      @(negedge CLK);
      dElig = d_req && !pDDone;
      fElig = if_req && !pIfDone;
      if (pValid && pReady) begin
        nCompared++;
        if ({mem_valid, if_done, d_done} !== {1'b0, owner == 1, owner == 2}) begin
          nMismatched++;
          $display("FAIL rnd_complete@%0d: valid/idone/ddone got %b%b%b owner %0d", cyc, mem_valid, if_done, d_done, owner);
        end
        if (owner == 2) begin
          if (!d_we) expDRdata = refRead(d_addr);
          else refStore(d_addr, d_wdata, d_wstrb);
          nCompared++;
          if (d_rdata !== expDRdata) begin nMismatched++; $display("FAIL rnd_drdata@%0d: got %h want %h", cyc, d_rdata, expDRdata); end
        end else begin
          expRd = refRead(if_addr);
          nCompared++;
          if (if_rdata !== expRd) begin nMismatched++; $display("FAIL rnd_irdata@%0d: got %h want %h", cyc, if_rdata, expRd); end
        end
        owner = 0;
      end else begin
        nCompared++;
        if ({if_done, d_done} !== 2'b00) begin nMismatched++; $display("FAIL rnd_spurious_done@%0d: got %b want 00", cyc, {if_done, d_done}); end
        if (pValid) begin
          nCompared++;
          if ({mem_valid, mem_we, mem_addr, mem_wstrb} !== {1'b1, sWe, sAddr, sStrb} || (sWe && mem_wdata !== sWdata)) begin
            nMismatched++;
            $display("FAIL rnd_hold@%0d: valid/we/addr/strb got %b%b/%h/%h want 1%b/%h/%h", cyc, mem_valid, mem_we, mem_addr, mem_wstrb, sWe, sAddr, sStrb);
          end
        end else begin
          nCompared++;
          if (mem_valid !== (dElig || fElig)) begin
            nMismatched++;
            $display("FAIL rnd_grant@%0d: mem_valid got %b want %b", cyc, mem_valid, dElig || fElig);
          end
          if (dElig || fElig) begin
            owner  = dElig ? 2 : 1;
            sWe    = dElig ? d_we : 1'b0;
            sAddr  = dElig ? d_addr : if_addr;
            sStrb  = (dElig && d_we) ? d_wstrb : 4'h0;
            sWdata = d_wdata;
            nCompared++;
            if ({mem_we, mem_addr, mem_wstrb} !== {sWe, sAddr, sStrb} || (sWe && mem_wdata !== sWdata)) begin
              nMismatched++;
              $display("FAIL rnd_owner@%0d: we/addr/strb got %b/%h/%h want %b/%h/%h", cyc, mem_we, mem_addr, mem_wstrb, sWe, sAddr, sStrb);
            end
          end
        end
      end
      nCompared++;
      if ({if_busy, d_busy, bus_err} !== {if_req && !if_done, d_req && !d_done, 1'b0}) begin
        nMismatched++;
        $display("FAIL rnd_busy@%0d: ibusy/dbusy/err got %b%b%b want %b%b0", cyc, if_busy, d_busy, bus_err, if_req && !if_done, d_req && !d_done);
      end
      pIfDone = if_done;
      pDDone  = d_done;
      pValid  = mem_valid;
      if (mem_valid) begin
        respWait++;
        if (respWait >= respLat) begin
          mem_ready = 1'b1;
          if (mem_we) bankStore(mem_addr, mem_wdata, mem_wstrb);
          mem_rdata = mem_we ? $urandom : bankRead(mem_addr);
          respWait = 0;
          respLat  = $urandom_range(1, 4);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        respWait  = 0;
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
      pReady = mem_ready;
      if (!if_req || if_done) begin
        if (cyc < nCycles && $urandom_range(0, 1) == 1) begin if_req = 1'b1; if_addr = randAddr(); end
        else if_req = 1'b0;
      end
      if (!d_req || d_done) begin
        if (cyc < nCycles && $urandom_range(0, 1) == 1) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = randAddr();
          d_wdata = $urandom; d_wstrb = 4'($urandom_range(1, 15));
        end else d_req = 1'b0;
      end
    end
    mem_ready = 1'b0;
    @(negedge CLK);
    nCompared++;
    if ({if_req, d_req, mem_valid} !== 3'b000) begin
      nMismatched++;
      $display("FAIL rnd_drain: ireq/dreq/valid got %b want 000", {if_req, d_req, mem_valid});
    end
  endtask

`ifdef UMA_TIMEOUT_EN
  task automatic test_timeout();
    int   validCycles = 0;
    logic gotDone = 1'b0;
    if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b0;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      @(negedge CLK);
      if (if_done) gotDone = 1'b1;
      else if (mem_valid) validCycles++;
    end
    nCompared++;
    if (gotDone !== 1'b1) begin nMismatched++; $display("FAIL timeout_done: no if_done within 40 cycles"); end
    nCompared++;
    if (validCycles !== 8) begin nMismatched++; $display("FAIL timeout_wait: got %0d stalled cycles want 8", validCycles); end
    nCompared++;
    if ({if_rdata, bus_err, mem_valid} !== {32'h0000_0013, 2'b10}) begin
      nMismatched++;
      $display("FAIL timeout_nop: rdata/err/valid got %h/%b%b want 00000013/10", if_rdata, bus_err, mem_valid);
    end
    if_req = 1'b0;
    repeat (3) @(negedge CLK);
    nCompared++;
    if (bus_err !== 1'b1) begin nMismatched++; $display("FAIL timeout_sticky: bus_err got %b want 1", bus_err); end
  endtask
`endif

  task automatic test_reset_mid_op();
    logic sawActivity = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_ready = 1'b0;
    @(negedge CLK);
    nCompared++;
    if (mem_valid !== 1'b1) begin nMismatched++; $display("FAIL rstmid_grant: mem_valid got %b want 1", mem_valid); end
    @(negedge CLK);
    RST = 1'b1; d_req = 1'b0;
    @(negedge CLK);
    nCompared++;
    if ({mem_valid, mem_we, if_done, d_done, bus_err, if_busy, d_busy} !== 7'b0) begin
      nMismatched++;
      $display("FAIL rstmid_ctrl: got %b want 0000000", {mem_valid, mem_we, if_done, d_done, bus_err, if_busy, d_busy});
    end
    nCompared++;
    if ({mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata} !== 132'b0) begin
      nMismatched++;
      $display("FAIL rstmid_data: got %h %h %h %h %h want all 0", mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata);
    end
    RST = 1'b0;
    expDRdata = '0;
    repeat (3) begin
      @(negedge CLK);
      if (d_done || mem_valid) sawActivity = 1'b1;
    end
    nCompared++;
    if (sawActivity !== 1'b0) begin nMismatched++; $display("FAIL rstmid_quiet: done or valid seen after reset"); end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_slow_memory();
    test_held_request();
    test_random(800);
`ifdef UMA_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
